// File: rtl/tanh_pwl_pipe.sv
// Three-stage pipelined piecewise-linear tanh in signed fixed point, with
// valid/ready flow control and a saturating count of saturated outputs.
module tanh_pwl_pipe #(
    parameter int WIDTH      = 8,
    parameter int FRAC       = 5,
    parameter int APPROX_LSB = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             clr_cnt,
    output logic [15:0]      sat_count
);

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1) << FRAC;
    localparam logic [WIDTH-1:0] HALF  = ONE >> 1;
    localparam logic [WIDTH-1:0] QUART = ONE >> 2;
    localparam logic [WIDTH-1:0] TWO   = ONE << 1;
    localparam logic [WIDTH-1:0] APPROX_MASK = ~((WIDTH'(1) << APPROX_LSB) - WIDTH'(1));

    logic             w_stall;
    logic             w_adv;
    logic             w_neg;
    logic [WIDTH-1:0] w_mag;
    logic [1:0]       w_seg;
    logic [WIDTH-1:0] w_y_raw;
    logic [WIDTH-1:0] w_y;

    logic             r_s1_valid;
    logic             r_s1_neg;
    logic [WIDTH-1:0] r_s1_mag;
    logic [1:0]       r_s1_seg;
    logic             r_s1_mode;

    logic             r_s2_valid;
    logic             r_s2_neg;
    logic [WIDTH-1:0] r_s2_y;
    logic             r_s2_sat;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_s3_sat;
    logic [15:0]      r_sat_count;

    assign w_stall   = r_out_valid & ~out_ready;
    assign w_adv     = ~w_stall;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sat_count = r_sat_count;

    // Unsigned magnitude: the most negative input maps to 2^(WIDTH-1), which
    // always lands in the saturated segment because FRAC <= WIDTH-3.
    assign w_neg = in_data[WIDTH-1];
    assign w_mag = w_neg ? (~in_data + WIDTH'(1)) : in_data;

    always_comb begin
        w_seg = 2'd3;
        if (w_mag < HALF)
            w_seg = 2'd0;
        else if (w_mag < ONE)
            w_seg = 2'd1;
        else if (w_mag < TWO)
            w_seg = 2'd2;
    end

    always_comb begin
        w_y_raw = ONE - WIDTH'(1);
        case (r_s1_seg)
            2'd0:    w_y_raw = r_s1_mag;
            2'd1:    w_y_raw = (r_s1_mag >> 1) + QUART;
            2'd2:    w_y_raw = (r_s1_mag >> 2) + HALF;
            default: w_y_raw = ONE - WIDTH'(1);
        endcase
        w_y = r_s1_mode ? (w_y_raw & APPROX_MASK) : w_y_raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_neg   <= 1'b0;
            r_s1_mag   <= '0;
            r_s1_seg   <= 2'd0;
            r_s1_mode  <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_neg   <= w_neg;
            r_s1_mag   <= w_mag;
            r_s1_seg   <= w_seg;
            r_s1_mode  <= in_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_neg   <= 1'b0;
            r_s2_y     <= '0;
            r_s2_sat   <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_neg   <= r_s1_neg;
            r_s2_y     <= w_y;
            r_s2_sat   <= (r_s1_seg == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_s3_sat    <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s2_valid;
            r_out_data  <= r_s2_neg ? (-r_s2_y) : r_s2_y;
            r_s3_sat    <= r_s2_sat;
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sat_count <= 16'd0;
        else if (clr_cnt)
            r_sat_count <= 16'd0;
        else if (r_out_valid && out_ready && r_s3_sat && (r_sat_count != 16'hFFFF))
            r_sat_count <= r_sat_count + 16'd1;
    end

endmodule

// File: tb/tb_tanh_pwl_pipe.sv
// Bench for tanh_pwl_pipe: arithmetic reference model with an expectation
// queue checked every cycle, plus directed literal vectors.
module tb_tanh_pwl_pipe;

    localparam int W  = 8;
    localparam int FR = 5;
    localparam int AL = 2;
    localparam int ONE_I = 1 << FR;
    localparam int MIN_I = -(1 << (W - 1));

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         clr_cnt;
    logic [15:0]  sat_count;

    tanh_pwl_pipe #(.WIDTH(W), .FRAC(FR), .APPROX_LSB(AL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .clr_cnt   (clr_cnt),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int y;
        bit sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_out   = 0;
    int   m_sat   = 0;
    bit   bp_en   = 1'b0;

    function automatic int ref_y(int x, bit m);
        int a;
        int y;
        a = (x < 0) ? -x : x;
        if (x == MIN_I || a >= 2 * ONE_I)
            y = ONE_I - 1;
        else if (a < ONE_I / 2)
            y = a;
        else if (a < ONE_I)
            y = a / 2 + ONE_I / 4;
        else
            y = a / 4 + ONE_I / 2;
        if (m)
            y = y - (y % (1 << AL));
        return (x < 0) ? -y : y;
    endfunction

    function automatic bit ref_sat(int x);
        int a;
        a = (x < 0) ? -x : x;
        return (x == MIN_I) || (a >= 2 * ONE_I);
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_total++;
        if (act == expv)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    // Random backpressure when enabled, otherwise always ready.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Per-cycle compare against the reference model.
    initial begin
        bit       prev_stall = 1'b0;
        logic [W-1:0] prev_data = '0;
        exp_t     e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_sat      = 0;
                prev_stall = 1'b0;
            end else begin
                chk("in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
                if (prev_stall) begin
                    chk("stall_valid_hold", int'(out_valid), 1);
                    chk("stall_data_hold", int'(out_data), int'(prev_data));
                end
                e.sat = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_output: got %0d, expected no output (t=%0t)",
                                 $signed(out_data), $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("model_out", int'($signed(out_data)), e.y);
                        n_out++;
                    end
                end
                chk("sat_count", int'(sat_count), m_sat);
                if (clr_cnt)
                    m_sat = 0;
                else if (out_valid && out_ready && e.sat && m_sat < 65535)
                    m_sat++;
                if (in_valid && in_ready) begin
                    e.y   = ref_y(int'($signed(in_data)), in_mode);
                    e.sat = ref_sat(int'($signed(in_data)));
                    exp_q.push_back(e);
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send(input int x, input bit m);
        bit acc;
        in_valid = 1'b1;
        in_data  = W'(x);
        in_mode  = m;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic direct(input int x, input bit m, input int expv);
        int lat;
        send(x, m);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_mode  = 1'($urandom);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        chk($sformatf("latency_x%0d", x), lat, 3);
        chk($sformatf("literal_x%0d_m%0d", x, m), int'($signed(out_data)), expv);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int n0;
        int bp_vals[10] = '{5, -20, 31, -60, 70, -128, 127, 0, 44, -9};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_mode  = 1'b0;
        clr_cnt  = 1'b0;
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_sat_count", int'(sat_count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        chk("pin_model_24", ref_y(24, 1'b0), 20);
        chk("pin_model_40m1", ref_y(40, 1'b1), 24);
        chk("pin_model_sat", int'(ref_sat(70)), 1);

        direct(8, 1'b0, 8);
        direct(24, 1'b0, 20);
        direct(48, 1'b0, 28);
        direct(100, 1'b0, 31);
        direct(-24, 1'b0, -20);
        direct(-128, 1'b0, -31);
        direct(40, 1'b1, 24);
        direct(-40, 1'b1, -24);
        direct(40, 1'b0, 26);

        send(40, 1'b1); send(40, 1'b0); send(-40, 1'b1);
        send(-40, 1'b0); send(20, 1'b1); send(20, 1'b0);
        in_valid = 1'b0;
        drain();

        for (int m = 0; m < 2; m++)
            for (int x = -128; x < 128; x++)
                send(x, 1'(m));
        in_valid = 1'b0;
        drain();

        n0 = n_out;
        bp_en = 1'b1;
        for (int i = 0; i < 10; i++)
            send(bp_vals[i], 1'(i % 2));
        in_valid = 1'b0;
        drain();
        bp_en = 1'b0;
        chk("bp_delivered", n_out - n0, 10);
        @(posedge clk);
        #1;

        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) send(70, 1'b0);
        send(10, 1'b0); send(-5, 1'b1); send(20, 1'b0);
        in_valid = 1'b0;
        drain();
        chk("sat_count_5", int'(sat_count), 5);
        send(70, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        chk("clr_priority", int'(sat_count), 0);
        drain();

        send(10, 1'b0); send(70, 1'b0); send(-30, 1'b0);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_sat_count", int'(sat_count), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_quiet", int'(out_valid), 0);
        direct(8, 1'b0, 8);
        direct(-128, 1'b1, -28);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tanh_pwl_pipe.md
TANH_PWL_PIPE -- requirements
Module: tanh_pwl_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: input/output word width, legal range 4..16.
REQ-002 SHALL have parameter FRAC, default 5: fractional bits of the two's-complement fixed-point format, legal range 1..WIDTH-3.
REQ-003 SHALL have parameter APPROX_LSB, default 2: magnitude LSBs cleared in approximate mode, legal range 0..FRAC-1.
REQ-004 SHALL have one clock and an asynchronous active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  input sample valid.
REQ-008 in_ready  output  1  block accepts an input sample this cycle.
REQ-009 in_data  input  WIDTH  signed sample x.
REQ-010 in_mode  input  1  0 = exact piecewise-linear, 1 = approximate; travels with its sample.
REQ-011 out_valid  output  1  output sample valid.
REQ-012 out_ready  input  1  downstream accepts the output sample.
REQ-013 out_data  output  WIDTH  signed tanh(x) in the same format as in_data.
REQ-014 clr_cnt  input  1  synchronous clear of sat_count.
REQ-015 sat_count  output  16  count of accepted saturated outputs.

Function
REQ-016 SHALL use ONE = 2^FRAC and a = |x| in LSB units; x = -2^(WIDTH-1) SHALL be treated as saturated.
REQ-017 SHALL compute magnitude y: a < ONE/2 -> y = a; a < ONE -> y = floor(a/2) + ONE/4; a < 2*ONE -> y = floor(a/4) + ONE/2; otherwise y = ONE-1, flagged saturated.
REQ-018 Mode 1 SHALL clear the low APPROX_LSB bits of y; mode 0 SHALL leave y unmodified.
REQ-019 out_data SHALL be y for x >= 0 and -y for x < 0, giving exact odd symmetry.
REQ-020 SHALL be a 3-stage pipeline: S1 registers sign, magnitude, segment and mode; S2 registers y; S3 is the output register.
REQ-021 Latency SHALL be exactly 3 cycles from the in_valid&in_ready edge to out_valid when out_ready is held high.
REQ-022 Throughput SHALL be one sample per cycle when out_ready is held high.
REQ-023 Stall is defined as out_valid & ~out_ready.
REQ-024 While stalled, all stages SHALL hold and in_ready SHALL be 0.
REQ-025 in_ready SHALL be ~stall, a combinational function of registered out_valid and out_ready.
REQ-026 When not stalled, every stage SHALL advance, with per-stage valid bits propagating bubbles.
REQ-027 No sample SHALL be dropped or duplicated under any valid/ready pattern.
REQ-028 out_data SHALL remain stable while out_valid & ~out_ready.
REQ-029 sat_count SHALL increment by 1 on each cycle with out_valid & out_ready & saturated flag.
REQ-030 sat_count SHALL hold at 0xFFFF and never wrap.
REQ-031 clr_cnt SHALL zero sat_count next cycle and SHALL take priority over a simultaneous increment.
REQ-032 in_data and in_mode SHALL be ignored when in_valid is 0 or in_ready is 0.

Reset
REQ-033 rst_n low SHALL immediately clear all stage valid bits, out_valid, out_data and sat_count to 0, including mid-stream.
REQ-034 in_ready SHALL be 1 during reset and after reset release.
REQ-035 The first accepted sample after reset release SHALL appear 3 cycles later.
REQ-036 Samples in flight at reset assertion SHALL be discarded.

Verification (WIDTH=8, FRAC=5, APPROX_LSB=2, out_ready=1 unless stated)
REQ-037 Mode 0 sweep SHALL produce x=8->8, 24->20, 48->28, 100->31, -24->-20, -128->-31 (0xE1), each 3 cycles after acceptance.
REQ-038 Mode 1 SHALL produce x=40->24 and x=-40->-24; mode 0 SHALL produce x=40->26; per-sample mode alternation SHALL be honoured.
REQ-039 Backpressure: streaming 10 samples with out_ready toggled pseudo-randomly SHALL deliver all 10 in order, values matching REQ-017..019, with out_data stable during stalls.
REQ-040 Exhaustive: all 256 inputs in both modes SHALL match a reference model.
REQ-041 Counter: 5 saturated samples (x=70) plus 3 non-saturated SHALL give sat_count=5; clr_cnt asserted together with a saturated acceptance SHALL give 0.
REQ-042 Reset mid-stream: rst_n pulsed low with 3 samples in flight SHALL give out_valid=0 immediately and no output of the discarded samples.
